// File: rtl/cnt_pkg.sv
// Shared definitions for the display-counter run controller: state codes,
// default counter width and display nibble width.
package cnt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int CNT_WIDTH_DEF = 27;
    localparam int NIB_W         = 4;

endpackage

// File: rtl/cnt_prescale.sv
// Clock-enable generator for cnt_sched: one enable every PRESCALE cycles,
// cleared on run start/stop and frozen while paused. Built only with CNT_SCHED_PRESCALE_EN.
`ifdef CNT_SCHED_PRESCALE_EN
module cnt_prescale
    import cnt_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clkin,
    input  logic rst0,
    input  logic clr,
    input  logic hold,
    output logic en
);

    localparam logic [7:0] LAST = 8'(PRESCALE - 1);

    logic [7:0] div;

    assign en = (div == LAST);

    always_ff @(posedge clkin or negedge rst0) begin
        if (!rst0) begin
            div <= 8'd0;
        end else if (clr) begin
            div <= 8'd0;
        end else if (!hold) begin
            div <= en ? 8'd0 : div + 8'd1;
        end
    end

endmodule
`endif

// File: rtl/cnt_sched.sv
// Run controller and counter register for the free-running display counter.
// Optional enable prescaler is compiled in with `define CNT_SCHED_PRESCALE_EN.
module cnt_sched
    import cnt_pkg::*;
#(
    parameter int WIDTH    = CNT_WIDTH_DEF,
    parameter int NIB_LSB  = WIDTH - 4,
    parameter int PRESCALE = 1
) (
    input  logic             clkin,
    input  logic             rst0,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic             periodic,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] cfg_tc,
    output logic             tick,
    output logic             done,
    output logic             busy,
    output logic [1:0]       st,
    output logic [NIB_W-1:0] out
);

    // Elaboration-time guards on the configuration.
    if (WIDTH < 4) begin : g_bad_width
        $error("cnt_sched: WIDTH must be at least 4");
    end
    if (NIB_LSB < 0 || NIB_LSB + NIB_W > WIDTH) begin : g_bad_nib
        $error("cnt_sched: display slice outside the counter");
    end
    if (PRESCALE < 1 || PRESCALE > 255) begin : g_bad_prescale
        $error("cnt_sched: PRESCALE must be in 1..255");
    end

    state_t           state, state_d;
    logic [WIDTH-1:0] count, count_d;
    logic [WIDTH-1:0] tc, tc_d;
    logic             mode, mode_d;
    logic             done_d;
    logic             tick_d;
    logic             en;

`ifdef CNT_SCHED_PRESCALE_EN
    logic pre_clr;
    logic pre_hold;

    // The divider restarts whenever a fresh run begins or the run is aborted.
    assign pre_clr  = stop || (start && (state == ST_IDLE || state == ST_DONE));
    assign pre_hold = (state == ST_PAUSE);

    cnt_prescale #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clkin (clkin),
        .rst0  (rst0),
        .clr   (pre_clr),
        .hold  (pre_hold),
        .en    (en)
    );
`else
    assign en = 1'b1;
`endif

    assign busy = (state == ST_RUN) || (state == ST_PAUSE);
    assign st   = state;

    always_comb begin
        state_d = state;
        count_d = count;
        tc_d    = tc;
        mode_d  = mode;
        done_d  = done;
        tick_d  = 1'b0;

        if (cfg_load && (state == ST_IDLE || state == ST_DONE)) begin
            tc_d = cfg_tc;
        end

        if (stop) begin
            state_d = ST_IDLE;
            count_d = '0;
            done_d  = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        count_d = '0;
                        mode_d  = periodic;
                    end
                end
                ST_RUN: begin
                    // The terminal edge wins over pause; pause applies from the next edge.
                    if (en && count == tc) begin
                        tick_d = 1'b1;
                        if (mode) begin
                            count_d = '0;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (en) begin
                        count_d = count + WIDTH'(1);
                    end
                end
                ST_PAUSE: begin
                    if (!pause && start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        count_d = '0;
                        done_d  = 1'b0;
                        mode_d  = periodic;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clkin or negedge rst0) begin
        if (!rst0) begin
            state <= ST_IDLE;
            count <= '0;
            tc    <= '1;
            mode  <= 1'b1;
            tick  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
        end else begin
            state <= state_d;
            count <= count_d;
            tc    <= tc_d;
            mode  <= mode_d;
            tick  <= tick_d;
            done  <= done_d;
            out   <= count[NIB_LSB +: NIB_W];
        end
    end

endmodule

// File: tb/tb_cnt_sched.sv
// Directed scoreboard bench for cnt_sched: 27-bit default instance plus an
// 8-bit instance used to reach the all-ones wrap in a short run.
module tb_cnt_sched;

    logic        clkin = 1'b0;
    logic        rst0;
    logic        start, pause, stop, periodic, cfg_load;
    logic [26:0] cfg_tc;
    logic        tick, done, busy;
    logic [1:0]  st;
    logic [3:0]  out;

    logic        start8, periodic8;
    logic        tick8, done8, busy8;
    logic [1:0]  st8;
    logic [3:0]  out8;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        string       tag;
        logic [26:0] cnt;
        logic        tk;
        logic [1:0]  s;
        logic        dn;
        logic [3:0]  o;
        bit          d8;
    } exp_t;

    exp_t sb[$];

    always #5 clkin = ~clkin;

    cnt_sched dut (
        .clkin    (clkin),
        .rst0     (rst0),
        .start    (start),
        .pause    (pause),
        .stop     (stop),
        .periodic (periodic),
        .cfg_load (cfg_load),
        .cfg_tc   (cfg_tc),
        .tick     (tick),
        .done     (done),
        .busy     (busy),
        .st       (st),
        .out      (out)
    );

    cnt_sched #(.WIDTH(8)) dut8 (
        .clkin    (clkin),
        .rst0     (rst0),
        .start    (start8),
        .pause    (1'b0),
        .stop     (1'b0),
        .periodic (periodic8),
        .cfg_load (1'b0),
        .cfg_tc   (8'h00),
        .tick     (tick8),
        .done     (done8),
        .busy     (busy8),
        .st       (st8),
        .out      (out8)
    );

    task automatic push(input string tg, input int c, input bit tk, input int s,
                        input bit dn, input int o = 0, input bit d8 = 1'b0);
        exp_t e;
        e.tag = tg;
        e.cnt = 27'(c);
        e.tk  = tk;
        e.s   = 2'(s);
        e.dn  = dn;
        e.o   = 4'(o);
        e.d8  = d8;
        sb.push_back(e);
    endtask

    task automatic chk();
        exp_t        e;
        logic [26:0] c;
        logic        tk, dn, b, eb;
        logic [1:0]  s;
        logic [3:0]  o;
        if (sb.size() == 0) begin
            nvec++;
            nerr++;
            $error("FAIL scoreboard_empty got 0 entries want 1");
            return;
        end
        e = sb.pop_front();
        if (e.d8) begin
            c = {19'd0, dut8.count}; tk = tick8; s = st8; dn = done8; o = out8; b = busy8;
        end else begin
            c = dut.count; tk = tick; s = st; dn = done; o = out; b = busy;
        end
        eb = (e.s == 2'd1) || (e.s == 2'd2);
        nvec++;
        assert (c === e.cnt) else begin
            nerr++; $error("FAIL %s.count got %0h want %0h", e.tag, c, e.cnt);
        end
        nvec++;
        assert (tk === e.tk) else begin
            nerr++; $error("FAIL %s.tick got %0b want %0b", e.tag, tk, e.tk);
        end
        nvec++;
        assert (s === e.s) else begin
            nerr++; $error("FAIL %s.st got %0d want %0d", e.tag, s, e.s);
        end
        nvec++;
        assert (dn === e.dn) else begin
            nerr++; $error("FAIL %s.done got %0b want %0b", e.tag, dn, e.dn);
        end
        nvec++;
        assert (o === e.o) else begin
            nerr++; $error("FAIL %s.out got %0h want %0h", e.tag, o, e.o);
        end
        nvec++;
        assert (b === eb) else begin
            nerr++; $error("FAIL %s.busy got %0b want %0b", e.tag, b, eb);
        end
    endtask

    task automatic cyc();
        @(posedge clkin);
        #1;
        chk();
    endtask

    task automatic chk_tc(input string tg, input logic [26:0] want);
        nvec++;
        assert (dut.tc === want) else begin
            nerr++; $error("FAIL %s.tc got %0h want %0h", tg, dut.tc, want);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0; periodic = 1'b1;
        cfg_load = 1'b0; cfg_tc = '0; start8 = 1'b0; periodic8 = 1'b1;

        #12;
        push("rst", 0, 0, 0, 0); chk();
        chk_tc("rst", {27{1'b1}});
        @(negedge clkin); rst0 = 1'b1;

        // Reset asserted mid-run at count 5
        @(posedge clkin); #1;
        start = 1'b1; periodic = 1'b1;
        push("mr_start", 0, 0, 1, 0); cyc();
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push("mr_run", i, 0, 1, 0); cyc();
        end
        #2 rst0 = 1'b0;
        #1 push("mr_async", 0, 0, 0, 0); chk();
        @(negedge clkin); rst0 = 1'b1;

        // Periodic, tc=3
        cfg_load = 1'b1; cfg_tc = 27'd3;
        push("p3_load", 0, 0, 0, 0); cyc();
        cfg_load = 1'b0;
        chk_tc("p3_load", 27'd3);
        start = 1'b1; periodic = 1'b1;
        push("p3_start", 0, 0, 1, 0); cyc();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            push("p3_run", k % 4, (k % 4) == 0, 1, 0); cyc();
        end
        stop = 1'b1;
        push("p3_stop", 0, 0, 0, 0); cyc();
        stop = 1'b0;

        // One-shot, tc=2, then restart from DONE
        cfg_load = 1'b1; cfg_tc = 27'd2;
        push("os_load", 0, 0, 0, 0); cyc();
        cfg_load = 1'b0;
        start = 1'b1; periodic = 1'b0;
        push("os_start", 0, 0, 1, 0); cyc();
        start = 1'b0;
        push("os_c1", 1, 0, 1, 0); cyc();
        push("os_c2", 2, 0, 1, 0); cyc();
        push("os_term", 2, 1, 3, 1); cyc();
        push("os_hold", 2, 0, 3, 1); cyc();
        start = 1'b1;
        push("os_restart", 0, 0, 1, 0); cyc();
        start = 1'b0;
        push("os_re_c1", 1, 0, 1, 0); cyc();
        stop = 1'b1;
        push("os_stop", 0, 0, 0, 0); cyc();
        stop = 1'b0;

        // tc=0 in both modes
        cfg_load = 1'b1; cfg_tc = 27'd0;
        push("z_load", 0, 0, 0, 0); cyc();
        cfg_load = 1'b0;
        start = 1'b1; periodic = 1'b1;
        push("zp_start", 0, 0, 1, 0); cyc();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push("zp_tick", 0, 1, 1, 0); cyc();
        end
        stop = 1'b1;
        push("zp_stop", 0, 0, 0, 0); cyc();
        stop = 1'b0;
        start = 1'b1; periodic = 1'b0;
        push("zo_start", 0, 0, 1, 0); cyc();
        start = 1'b0;
        push("zo_done", 0, 1, 3, 1); cyc();
        stop = 1'b1;
        push("zo_stop", 0, 0, 0, 0); cyc();
        stop = 1'b0;

        // Pause/resume, tc=9 periodic
        cfg_load = 1'b1; cfg_tc = 27'd9;
        push("pr_load", 0, 0, 0, 0); cyc();
        cfg_load = 1'b0;
        start = 1'b1; periodic = 1'b1;
        push("pr_start", 0, 0, 1, 0); cyc();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push("pr_run", i, 0, 1, 0); cyc();
        end
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin cfg_load = 1'b1; cfg_tc = 27'd2; end
            if (i == 3) start = 1'b1;
            push("pr_paused", 4, 0, 2, 0); cyc();
            cfg_load = 1'b0; start = 1'b0;
        end
        chk_tc("pr_cfg_ignored", 27'd9);
        pause = 1'b0; start = 1'b1;
        push("pr_resume", 4, 0, 1, 0); cyc();
        start = 1'b0;
        for (int i = 5; i <= 9; i++) begin
            push("pr_after", i, 0, 1, 0); cyc();
        end
        push("pr_tick", 0, 1, 1, 0); cyc();
        for (int i = 1; i <= 9; i++) begin
            push("pr_run2", i, 0, 1, 0); cyc();
        end

        // pause on the terminal edge, then a three-way command collision
        pause = 1'b1;
        push("pt_term", 0, 1, 1, 0); cyc();
        push("pt_pause", 0, 0, 2, 0); cyc();
        pause = 1'b0; start = 1'b1;
        push("pt_resume", 0, 0, 1, 0); cyc();
        start = 1'b0;
        push("pt_c1", 1, 0, 1, 0); cyc();
        stop = 1'b1; pause = 1'b1; start = 1'b1;
        push("prio_all", 0, 0, 0, 0); cyc();
        stop = 1'b0; pause = 1'b0; start = 1'b0;

        // All-ones wrap on the 8-bit instance (display slice is count[7:4])
        start8 = 1'b1; periodic8 = 1'b1;
        push("w_start", 0, 0, 1, 0, 0, 1'b1); cyc();
        start8 = 1'b0;
        repeat (253) @(posedge clkin);
        #1;
        push("w_fd", 253, 0, 1, 0, 15, 1'b1); chk();
        push("w_fe", 254, 0, 1, 0, 15, 1'b1); cyc();
        push("w_ff", 255, 0, 1, 0, 15, 1'b1); cyc();
        push("w_wrap", 0, 1, 1, 0, 15, 1'b1); cyc();
        push("w_after", 1, 0, 1, 0, 0, 1'b1); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/cnt_sched.md
Name: cnt_sched

Overview:
- Run controller for the 27-bit free-running display counter: sequences start, pause, resume and stop, and compares against a programmable terminal count.
- Produces a single-cycle period tick, a one-shot done flag and the registered top nibble of the count for LED display.
- Sits between the board push-button/config logic and the counter datapath; owns the counter register itself.

Parameters:
- WIDTH, 27, counter width in bits (minimum 4).
- NIB_LSB, WIDTH-4, LSB index of the 4-bit display slice; the slice is count[NIB_LSB+3:NIB_LSB].
- PRESCALE, 1, clock-enable divider ratio (1..255); used only when the optional feature is compiled in.

Ports:
- clkin  in  1  system clock, all logic on its rising edge.
- rst0  in  1  reset, asynchronous assert, active-low.
- start  in  1  level-sampled; start from IDLE/DONE, resume from PAUSE.
- pause  in  1  level-sampled; freeze the count while in RUN.
- stop  in  1  level-sampled; abort to IDLE.
- periodic  in  1  1 = reload on terminal count, 0 = one-shot; sampled on start from IDLE/DONE.
- cfg_load  in  1  latch cfg_tc into the terminal-count register.
- cfg_tc  in  WIDTH  terminal count value.
- tick  out  1  one-cycle pulse on terminal count.
- done  out  1  one-shot complete, held until the next start or stop.
- busy  out  1  high in RUN or PAUSE.
- st  out  2  state code: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- out  out  4  registered display nibble.

Behaviour:
- Reset (rst0 low, asynchronous): state=IDLE, count=0, tc=all ones, mode=periodic, tick=0, done=0, out=0.
- cfg_load is accepted only in IDLE or DONE; tc takes cfg_tc at that edge. In RUN or PAUSE it is ignored.
- Command priority per edge: stop > pause > start. Simultaneous commands resolve by this priority.
- IDLE + start: count<=0, latch the mode from periodic, go to RUN.
- RUN:
  - If count != tc, count<=count+1.
  - If count == tc, pulse tick (registered, high the next cycle only).
    - Periodic: count<=0 and stay in RUN.
    - One-shot: count holds tc, state<=DONE, done<=1.
  - The terminal-count edge completes even if pause is asserted in the same cycle. pause then takes effect from the resulting state, and is ignored in DONE.
- RUN + pause (count != tc): go to PAUSE; count holds.
- PAUSE + start: go to RUN without clearing the count. pause and start both high in PAUSE: stay in PAUSE.
- DONE + start: clear count and done, go to RUN (restart).
- Any state + stop: IDLE, count<=0, done<=0, tick<=0.
- Period: tc+1 enabled cycles. tc=0 periodic gives tick every enabled cycle. tc=0 one-shot reaches DONE after one cycle in RUN.
- Wrap: with tc=all ones, count reaches 2^WIDTH-1 and then clears. count never overflows past tc.
- out <= count[NIB_LSB+3:NIB_LSB] every edge, so it lags count by one cycle. Reset clears it.
- busy and st decode combinationally from the state register.
- If tc is reloaded below the current count while in DONE, there is no effect until the next start clears count.

Optional Feature:
- Macro: CNT_SCHED_PRESCALE_EN.
- Defined:
  - An 8-bit prescaler emits an enable every PRESCALE clkin cycles. Count, compare and terminal actions advance only on enabled cycles.
  - tick aligns to the enabled cycle. The prescaler clears on start from IDLE/DONE and on stop, and holds during PAUSE.
  - Commands (start, pause, stop) still act on any edge.
- Undefined: the enable is constant 1 and no prescaler register exists. Behaviour is identical to PRESCALE=1.

Decomposition:
- Shared package (cnt_pkg): state encoding constants (ST_IDLE..ST_DONE), the default WIDTH, and the display-nibble width of 4.
- One sub-module, cnt_prescale (enable generator: clear, hold, PRESCALE), instantiated only under CNT_SCHED_PRESCALE_EN. The counter and FSM stay in cnt_sched.

Test Plan:
- Reset mid-RUN: rst0 low at count=5 -> st=0, count=0, out=0, tick=0 immediately, without waiting for a clkin edge.
- Periodic, tc=3: cfg_load, then start -> tick on cycles 4, 8, 12 after start; count sequence 0,1,2,3,0; busy=1 throughout.
- One-shot, tc=2: start with periodic=0 -> one tick, then st=3, done=1, count holds 2. A second start restarts from 0 and clears done.
- Pause/resume, tc=9 periodic: pause at count=4 for 6 cycles, then start -> count resumes at 5; the tick is delayed by exactly 6 cycles. cfg_load during PAUSE leaves tc=9.
- Priority: stop+pause+start in the same RUN cycle -> IDLE, count=0. pause on the tc edge -> tick still fires and count clears.
- WIDTH=27 default, tc=all ones, force count to 0x7FFFFFE -> out reads 0xF one cycle later; count wraps to 0 with tick; out returns to 0.
